// File: rtl/keys_debounce.sv
// Per-key two-flop synchronizer and counter debouncer for active-low push-buttons,
// with one-cycle press/release strobes. Optional sticky press flags: KEYS_DEBOUNCE_PRESS_LATCH_EN.
module keys_debounce #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_db,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
`ifdef KEYS_DEBOUNCE_PRESS_LATCH_EN
   ,
   input  logic [NUM_KEYS-1:0] latch_clr,
   output logic [NUM_KEYS-1:0] press_latched
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] s1_q;
   logic [NUM_KEYS-1:0] s2_q;
   logic [NUM_KEYS-1:0] db_q;
   logic [NUM_KEYS-1:0] db_d;
   logic [NUM_KEYS-1:0] press_q;
   logic [NUM_KEYS-1:0] press_d;
   logic [NUM_KEYS-1:0] rel_q;
   logic [NUM_KEYS-1:0] rel_d;
   logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
   logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

   // Synchronizer resets to the released level so reset release never looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '1;
         s2_q <= '1;
      end else begin
         s1_q <= key_raw;
         s2_q <= s1_q;
      end
   end

   always_comb begin
      db_d = db_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      press_d = db_q & ~db_d;
      rel_d   = ~db_q & db_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_q    <= '1;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign key_db        = db_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;

`ifdef KEYS_DEBOUNCE_PRESS_LATCH_EN
   logic [NUM_KEYS-1:0] latched_q;
   logic [NUM_KEYS-1:0] latched_d;

   // Set takes priority over a coincident clear so no press is ever lost.
   always_comb begin
      latched_d = (latched_q & ~latch_clr) | press_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         latched_q <= '0;
      end else begin
         latched_q <= latched_d;
      end
   end

   assign press_latched = latched_q;
`endif

endmodule

// File: tb/tb_keys_debounce.sv
// Self-checking bench for keys_debounce (DEBOUNCE_CYCLES=4); strobes are matched
// against a queue of expected (key, kind, edge) events.
module tb_keys_debounce;
   localparam int NK = 4;
   localparam int D  = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NK-1:0] key_raw = '1;
   logic [NK-1:0] key_db;
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;
`ifdef KEYS_DEBOUNCE_PRESS_LATCH_EN
   logic [NK-1:0] latch_clr = '0;
   logic [NK-1:0] press_latched;
`endif

   keys_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_raw       (key_raw),
      .key_db        (key_db),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
`ifdef KEYS_DEBOUNCE_PRESS_LATCH_EN
      ,
      .latch_clr     (latch_clr),
      .press_latched (press_latched)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int key;
      bit press;
      int edge_n;
   } ev_t;
   ev_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard: every strobe seen must match the next expected event exactly.
   always @(negedge clk) begin
      ev_t ev;
      logic hit;
      if (!reset_n) begin
         n_checks++;
         if (press_pulse !== '0 || release_pulse !== '0)
            $display("FAIL reset_strobe: press=%b release=%b required 0000/0000", press_pulse, release_pulse);
         else n_pass++;
      end else begin
         for (int k = 0; k < NK; k++) begin
            if (press_pulse[k] === 1'b1 && release_pulse[k] === 1'b1) begin
               n_checks++;
               $display("FAIL both_strobes key%0d: both high at edge %0d, required at most one", k, cyc);
            end
            for (int t = 0; t < 2; t++) begin
               hit = (t == 0) ? press_pulse[k] : release_pulse[k];
               if (hit === 1'b1) begin
                  n_checks++;
                  if (sb.size() == 0) begin
                     $display("FAIL unexpected_strobe: key%0d press=%0d at edge %0d, required none", k, (t == 0), cyc);
                  end else begin
                     ev = sb.pop_front();
                     if (ev.key != k || ev.press != (t == 0) || ev.edge_n != cyc)
                        $display("FAIL strobe_match: got key%0d press=%0d edge %0d, required key%0d press=%0d edge %0d",
                                 k, (t == 0), cyc, ev.key, ev.press, ev.edge_n);
                     else n_pass++;
                  end
               end
            end
         end
      end
   end

   task automatic test_reset;
      logic ok;
      reset_n = 1'b0;
      key_raw = '1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0)
         $display("FAIL reset_values: db=%h press=%h rel=%h required F/0/0", key_db, press_pulse, release_pulse);
      else n_pass++;
      reset_n = 1'b1;
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (key_db !== 4'hF) ok = 1'b0;
      end
      n_checks++;
      if (!ok) $display("FAIL idle_hold: key_db=%h required F for 100 cycles", key_db);
      else n_pass++;
   endtask

   task automatic test_single_press;
      int c, t;
      logic [NK-1:0] exp_db;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b0;
      t = c + D + 2;
      sb.push_back('{key: 0, press: 1'b1, edge_n: t});
      repeat (D + 4) begin
         @(negedge clk);
         exp_db = (cyc < t) ? 4'hF : 4'hE;
         n_checks++;
         if (key_db !== exp_db)
            $display("FAIL press_latency edge %0d: key_db=%h required %h", cyc, key_db, exp_db);
         else n_pass++;
      end
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b1;
      sb.push_back('{key: 0, press: 1'b0, edge_n: c + D + 2});
      repeat (D + 4) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hF || sb.size() != 0)
         $display("FAIL single_release: key_db=%h pending=%0d required F/0", key_db, sb.size());
      else n_pass++;
   endtask

   task automatic test_bounce;
      int c, t;
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (key_db[1] !== 1'b1) ok = 1'b0;
         if (i % 2 == 0) key_raw[1] = ~key_raw[1];
      end
      n_checks++;
      if (!ok) $display("FAIL bounce_reject: key_db[1] changed during bounce, required 1");
      else n_pass++;
      @(negedge clk);
      c = cyc;
      key_raw[1] = 1'b0;
      t = c + D + 2;
      sb.push_back('{key: 1, press: 1'b1, edge_n: t});
      repeat (D + 4) begin
         @(negedge clk);
         n_checks++;
         if (key_db[1] !== ((cyc < t) ? 1'b1 : 1'b0))
            $display("FAIL bounce_settle edge %0d: key_db[1]=%b required %b", cyc, key_db[1], (cyc < t));
         else n_pass++;
      end
      @(negedge clk);
      c = cyc;
      key_raw[1] = 1'b1;
      sb.push_back('{key: 1, press: 1'b0, edge_n: c + D + 2});
      repeat (D + 4) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hF || sb.size() != 0)
         $display("FAIL bounce_release: key_db=%h pending=%0d required F/0", key_db, sb.size());
      else n_pass++;
   endtask

   task automatic test_press_release;
      int c;
      @(negedge clk);
      c = cyc;
      key_raw[2] = 1'b0;
      sb.push_back('{key: 2, press: 1'b1, edge_n: c + D + 2});
      repeat (9) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hB)
         $display("FAIL key2_held: key_db=%h required b", key_db);
      else n_pass++;
      @(negedge clk);
      c = cyc;
      key_raw[2] = 1'b1;
      sb.push_back('{key: 2, press: 1'b0, edge_n: c + D + 2});
      repeat (D + 6) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hF || sb.size() != 0)
         $display("FAIL key2_release: key_db=%h pending=%0d required F/0", key_db, sb.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_count;
      int c, r, t;
      @(negedge clk);
      c = cyc;
      key_raw[3] = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (key_db !== 4'hF || press_pulse !== 4'h0)
         $display("FAIL reset_mid_count: key_db=%h press=%h required F/0", key_db, press_pulse);
      else n_pass++;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      r = cyc;
      t = r + D + 2;
      sb.push_back('{key: 3, press: 1'b1, edge_n: t});
      repeat (D + 4) begin
         @(negedge clk);
         n_checks++;
         if (key_db[3] !== ((cyc < t) ? 1'b1 : 1'b0))
            $display("FAIL post_reset_latency edge %0d: key_db[3]=%b required %b", cyc, key_db[3], (cyc < t));
         else n_pass++;
      end
      @(negedge clk);
      c = cyc;
      key_raw[3] = 1'b1;
      sb.push_back('{key: 3, press: 1'b0, edge_n: c + D + 2});
      repeat (D + 4) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hF || sb.size() != 0)
         $display("FAIL key3_release: key_db=%h pending=%0d required F/0", key_db, sb.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_pulse;
      int c;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b0;
      sb.push_back('{key: 0, press: 1'b1, edge_n: c + D + 2});
      repeat (D + 2) @(negedge clk);
      #1;
      n_checks++;
      if (press_pulse !== 4'h1 || key_db !== 4'hE)
         $display("FAIL pre_reset_pulse: press=%h key_db=%h required 1/E", press_pulse, key_db);
      else n_pass++;
      key_raw = '1;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (press_pulse !== 4'h0 || key_db !== 4'hF)
         $display("FAIL reset_mid_pulse: press=%h key_db=%h required 0/F", press_pulse, key_db);
      else n_pass++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (D + 6) @(negedge clk);
      n_checks++;
      if (key_db !== 4'hF || sb.size() != 0)
         $display("FAIL after_pulse_reset: key_db=%h pending=%0d required F/0", key_db, sb.size());
      else n_pass++;
   endtask

`ifdef KEYS_DEBOUNCE_PRESS_LATCH_EN
   task automatic test_press_latch;
      int c;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b0;
      sb.push_back('{key: 0, press: 1'b1, edge_n: c + D + 2});
      repeat (D + 3) @(negedge clk);
      n_checks++;
      if (press_latched[0] !== 1'b1) $display("FAIL latch_set: press_latched[0]=%b required 1", press_latched[0]);
      else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (press_latched[0] !== 1'b1) $display("FAIL latch_hold: press_latched[0]=%b required 1", press_latched[0]);
      else n_pass++;
      latch_clr[0] = 1'b1;
      @(negedge clk);
      latch_clr[0] = 1'b0;
      n_checks++;
      if (press_latched[0] !== 1'b0) $display("FAIL latch_clear: press_latched[0]=%b required 0", press_latched[0]);
      else n_pass++;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b1;
      sb.push_back('{key: 0, press: 1'b0, edge_n: c + D + 2});
      repeat (D + 4) @(negedge clk);
      n_checks++;
      if (press_latched !== 4'h0) $display("FAIL latch_release: press_latched=%h required 0", press_latched);
      else n_pass++;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b0;
      latch_clr[0] = 1'b1;
      sb.push_back('{key: 0, press: 1'b1, edge_n: c + D + 2});
      repeat (D + 2) @(negedge clk);
      latch_clr[0] = 1'b0;
      n_checks++;
      if (press_latched[0] !== 1'b1) $display("FAIL latch_set_wins: press_latched[0]=%b required 1", press_latched[0]);
      else n_pass++;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b1;
      sb.push_back('{key: 0, press: 1'b0, edge_n: c + D + 2});
      repeat (D + 4) @(negedge clk);
      n_checks++;
      if (press_latched[0] !== 1'b1 || sb.size() != 0)
         $display("FAIL latch_final: press_latched[0]=%b pending=%0d required 1/0", press_latched[0], sb.size());
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_press_release();
      test_reset_mid_count();
      test_reset_mid_pulse();
`ifdef KEYS_DEBOUNCE_PRESS_LATCH_EN
      test_press_latch();
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
